usb2_ep_sched: RTL

USB2_EP_SCHED -- requirements
Module: usb2_ep_sched

---
 rtl/usb2_ep_sched.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/usb2_ep_sched.sv
// Purpose: routes protocol-layer commit/arm requests to one of three endpoints and returns acknowledges.
// Latency: request edge to ep strobe is 2 phy_clk cycles; prot ack is held ACK_CYC cycles after the ep ack.
// Backpressure: ep strobe is held until the ep acks or TIMEOUT expires; edges arriving while busy are queued as pending.
module usb2_ep_sched #(
  parameter logic [7:0] TIMEOUT = 8'd255,
  parameter logic [2:0] ACK_CYC = 3'd4
) (
  input  logic       phy_clk,
  input  logic       reset_n,
  input  logic [3:0] sel_ep,
  input  logic       prot_commit,
  output logic       prot_commit_ack,
  input  logic       prot_arm,
  output logic       prot_arm_ack,
  output logic       prot_ready,
  output logic       prot_hasdata,
  output logic       prot_stall,
  output logic [2:0] ep_commit,
  input  logic [2:0] ep_commit_ack,
  output logic [2:0] ep_arm,
  input  logic [2:0] ep_arm_ack,
  input  logic [2:0] ep_ready,
  input  logic [2:0] ep_hasdata,
  output logic [1:0] route,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [2:0] {IDLE, C_REQ, A_REQ, C_ACK, A_ACK} state_t;

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Reset asserts asynchronously but releases two clocks later, which also
  // keeps the FSM in IDLE for two cycles after reset_n rises.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Request synchronizers; the edge is taken between stage 1 and stage 2.
  logic [1:0] cm_sync, am_sync;
  logic       commit_edge, arm_edge;

  always_ff @(posedge phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_sync <= 2'b00;
      am_sync <= 2'b00;
    end else begin
      cm_sync <= {cm_sync[0], prot_commit};
      am_sync <= {am_sync[0], prot_arm};
    end
  end
  assign commit_edge = cm_sync[0] & ~cm_sync[1];
  assign arm_edge    = am_sync[0] & ~am_sync[1];

  state_t     state, state_nxt;
  logic [1:0] route_nxt;
  logic       commit_pend, commit_pend_nxt, arm_pend, arm_pend_nxt;
  logic [3:0] commit_pend_ep, commit_pend_ep_nxt, arm_pend_ep, arm_pend_ep_nxt;
  logic [7:0] tcnt, tcnt_nxt, tcnt_inc;
  logic [2:0] hcnt, hcnt_nxt;
  logic [2:0] scnt, scnt_nxt;
  logic       err_nxt;
  logic       go, go_arm;
  logic [3:0] go_ep;

  always_ff @(posedge phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      route          <= 2'd0;
      commit_pend    <= 1'b0;
      commit_pend_ep <= 4'd0;
      arm_pend       <= 1'b0;
      arm_pend_ep    <= 4'd0;
      tcnt           <= 8'd0;
      hcnt           <= 3'd0;
      scnt           <= 3'd0;
      err_timeout    <= 1'b0;
    end else begin
      state          <= state_nxt;
      route          <= route_nxt;
      commit_pend    <= commit_pend_nxt;
      commit_pend_ep <= commit_pend_ep_nxt;
      arm_pend       <= arm_pend_nxt;
      arm_pend_ep    <= arm_pend_ep_nxt;
      tcnt           <= tcnt_nxt;
      hcnt           <= hcnt_nxt;
      scnt           <= scnt_nxt;
      err_timeout    <= err_nxt;
    end
  end

  // Saturating increment: the timeout counter never wraps.
  assign tcnt_inc = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;

  always_comb begin
    state_nxt          = state;
    route_nxt          = route;
    commit_pend_nxt    = commit_pend;
    commit_pend_ep_nxt = commit_pend_ep;
    arm_pend_nxt       = arm_pend;
    arm_pend_ep_nxt    = arm_pend_ep;
    tcnt_nxt           = tcnt;
    hcnt_nxt           = hcnt;
    scnt_nxt           = (scnt != 3'd0) ? scnt - 3'd1 : 3'd0;
    err_nxt            = 1'b0;
    go                 = 1'b0;
    go_arm             = 1'b0;
    go_ep              = 4'd0;

    case (state)
      IDLE: begin
        // Service order: pending commit, pending arm, new commit, new arm.
        if (commit_pend) begin
          go = 1'b1; go_ep = commit_pend_ep; commit_pend_nxt = 1'b0;
        end else if (arm_pend) begin
          go = 1'b1; go_arm = 1'b1; go_ep = arm_pend_ep; arm_pend_nxt = 1'b0;
        end else if (commit_edge) begin
          go = 1'b1; go_ep = sel_ep;
        end else if (arm_edge) begin
          go = 1'b1; go_arm = 1'b1; go_ep = sel_ep;
        end
        // Edges not serviced this cycle are queued with the endpoint they named.
        if (commit_edge && (commit_pend || arm_pend)) begin
          commit_pend_nxt    = 1'b1;
          commit_pend_ep_nxt = sel_ep;
        end
        if (arm_edge && (commit_pend || arm_pend || commit_edge)) begin
          arm_pend_nxt    = 1'b1;
          arm_pend_ep_nxt = sel_ep;
        end
        if (go) begin
          if (go_ep > 4'd2) begin
            // Unimplemented endpoint: stall, no strobe, route untouched.
            scnt_nxt = ACK_CYC;
          end else begin
            route_nxt = go_ep[1:0];
            tcnt_nxt  = 8'd0;
            state_nxt = go_arm ? A_REQ : C_REQ;
          end
        end
      end
      C_REQ, A_REQ: begin
        if (bit_at((state == C_REQ) ? ep_commit_ack : ep_arm_ack, route)) begin
          hcnt_nxt  = ACK_CYC - 3'd1;
          state_nxt = (state == C_REQ) ? C_ACK : A_ACK;
        end else if (tcnt_inc == TIMEOUT) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt_inc;
        end
      end
      C_ACK, A_ACK: begin
        if (hcnt == 3'd0) state_nxt = IDLE;
        else              hcnt_nxt  = hcnt - 3'd1;
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE) begin
      if (commit_edge) begin
        commit_pend_nxt    = 1'b1;
        commit_pend_ep_nxt = sel_ep;
      end
      if (arm_edge) begin
        arm_pend_nxt    = 1'b1;
        arm_pend_ep_nxt = sel_ep;
      end
    end
  end

  // Strobes and acks decode straight from state so reset drops them at once.
  assign ep_commit       = (state == C_REQ) ? onehot(route) : 3'b000;
  assign ep_arm          = (state == A_REQ) ? onehot(route) : 3'b000;
  assign prot_commit_ack = (state == C_ACK);
  assign prot_arm_ack    = (state == A_ACK);
  assign prot_stall      = (scnt != 3'd0);
  assign busy            = (state != IDLE);
  assign prot_ready      = ~prot_stall & bit_at(ep_ready, route);
  assign prot_hasdata    = ~prot_stall & bit_at(ep_hasdata, route);

endmodule
